// File: rtl/sci_master_seq_if.sv
// SCI sequencer bus bundle: host command/response handshake plus the SCI bus pins.
// Handshake: a command transfers on a clk edge where cmd_valid && cmd_ready; rsp_valid is a one-cycle pulse with no back-pressure.
interface sci_master_seq_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] sciaddr;
    logic [DATA_W-1:0] sciwdata;
    logic              sciwstn;
    logic              scird;
    logic [DATA_W-1:0] scirmxdata;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, scirmxdata,
        output cmd_ready, rsp_valid, rsp_rdata, sciaddr, sciwdata, sciwstn, scird
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, scirmxdata,
        input  cmd_ready, rsp_valid, rsp_rdata, sciaddr, sciwdata, sciwstn, scird
    );
endinterface

// File: rtl/sci_master_seq.sv
// Host-side SCI bus master: one command at a time, sequenced through setup, strobe,
// hold and a one-cycle response, with all SCI pins driven from registers.
module sci_master_seq #(
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 8,
    parameter int SETUP_CYC = 1,
    parameter int WSTB_CYC  = 2,
    parameter int RSTB_CYC  = 3,
    parameter int HOLD_CYC  = 1
) (
    input  logic              clk,
    input  logic              rst,
    sci_master_seq_if.master  bus,
    output logic [2:0]        o_state
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] WSTB_LD  = 4'(WSTB_CYC - 1);
    localparam logic [3:0] RSTB_LD  = 4'(RSTB_CYC - 1);
    localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

    if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
        $error("sci_master_seq: SETUP_CYC must be in 1..15");
    end
    if (WSTB_CYC < 1 || WSTB_CYC > 15) begin : g_bad_wstb
        $error("sci_master_seq: WSTB_CYC must be in 1..15");
    end
    if (RSTB_CYC < 1 || RSTB_CYC > 15) begin : g_bad_rstb
        $error("sci_master_seq: RSTB_CYC must be in 1..15");
    end
    if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
        $error("sci_master_seq: HOLD_CYC must be in 1..15");
    end

    logic [2:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic              r_wstn;
    logic              r_rd;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              w_ready;
    logic              w_accept;
    logic              w_cnt_done;

    // Ready is masked by rst so a command offered during reset is never taken.
    assign w_ready    = (r_state == S_IDLE) && !rst;
    assign w_accept   = bus.cmd_valid && w_ready;
    assign w_cnt_done = (r_cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_wstn      <= 1'b1;
            r_rd        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= bus.cmd_addr;
                        if (bus.cmd_we) r_wdata <= bus.cmd_wdata;
                        r_we    <= bus.cmd_we;
                        r_cnt   <= SETUP_LD;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_cnt_done) begin
                        r_state <= S_STROBE;
                        if (r_we) begin
                            r_cnt  <= WSTB_LD;
                            r_wstn <= 1'b0;
                        end else begin
                            r_cnt <= RSTB_LD;
                            r_rd  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_STROBE: begin
                    if (w_cnt_done) begin
                        r_state <= S_HOLD;
                        r_cnt   <= HOLD_LD;
                        r_wstn  <= 1'b1;
                        r_rd    <= 1'b0;
                        // Read data is captured on the edge that closes the strobe.
                        if (!r_we) r_rdata <= bus.scirmxdata;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_HOLD: begin
                    if (w_cnt_done) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_wstn      <= 1'b1;
                    r_rd        <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = w_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.sciaddr   = r_addr;
    assign bus.sciwdata  = r_wdata;
    assign bus.sciwstn   = r_wstn;
    assign bus.scird     = r_rd;
    assign o_state       = r_state;
endmodule

// File: tb/tb_sci_master_seq.sv
// Directed bench for sci_master_seq: a default-timing instance and a slow-timing instance,
// each attached to a small SCI register model; read data is predicted into a scoreboard queue.
module tb_sci_master_seq;
    localparam int AW = 18;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sci_master_seq_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
    sci_master_seq_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();
    logic [2:0] st0, st1;

    sci_master_seq #(.ADDR_W(AW), .DATA_W(DW)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.master), .o_state(st0)
    );
    sci_master_seq #(.ADDR_W(AW), .DATA_W(DW), .SETUP_CYC(3), .WSTB_CYC(1),
                     .RSTB_CYC(4), .HOLD_CYC(2)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.master), .o_state(st1)
    );

    logic          tb_valid;
    logic          tb_we;
    logic [AW-1:0] tb_addr;
    logic [DW-1:0] tb_wdata;
    int            tb_sel;

    assign if0.cmd_valid = tb_valid && (tb_sel == 0);
    assign if1.cmd_valid = tb_valid && (tb_sel == 1);
    assign if0.cmd_we    = tb_we;
    assign if1.cmd_we    = tb_we;
    assign if0.cmd_addr  = tb_addr;
    assign if1.cmd_addr  = tb_addr;
    assign if0.cmd_wdata = tb_wdata;
    assign if1.cmd_wdata = tb_wdata;

    // SCI register models: combinational read mux, write on the sciwstn rising edge.
    logic [DW-1:0] mem0 [32];
    logic [DW-1:0] mem1 [32];
    assign if0.scirmxdata = mem0[if0.sciaddr[4:0]];
    assign if1.scirmxdata = mem1[if1.sciaddr[4:0]];
    always @(posedge if0.sciwstn) if (!rst) mem0[if0.sciaddr[4:0]] = if0.sciwdata;
    always @(posedge if1.sciwstn) if (!rst) mem1[if1.sciaddr[4:0]] = if1.sciwdata;

    int n_chk  = 0;
    int n_pass = 0;
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Strobe watchers: strobes mutually exclusive, address steady across every strobe edge.
    logic          stb_prev0 = 1'b0, stb_prev1 = 1'b0;
    logic [AW-1:0] stb_addr0, stb_addr1;
    always @(negedge clk) begin
        if (rst) begin
            stb_prev0 = 1'b0;
            stb_prev1 = 1'b0;
        end else begin
            chk("strobe_excl0", {31'd0, !if0.sciwstn && if0.scird}, 32'd0);
            chk("strobe_excl1", {31'd0, !if1.sciwstn && if1.scird}, 32'd0);
            if (!if0.sciwstn || if0.scird) begin
                if (stb_prev0) chk("stb_addr_stable0", 32'(if0.sciaddr), 32'(stb_addr0));
                stb_addr0 = if0.sciaddr;
                stb_prev0 = 1'b1;
            end else stb_prev0 = 1'b0;
            if (!if1.sciwstn || if1.scird) begin
                if (stb_prev1) chk("stb_addr_stable1", 32'(if1.sciaddr), 32'(stb_addr1));
                stb_addr1 = if1.sciaddr;
                stb_prev1 = 1'b1;
            end else stb_prev1 = 1'b0;
        end
    end

    // Issues one command at a negedge and checks every cycle until the one after the response.
    task automatic do_cmd(input int sel, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input int stb_first, input int stb_last,
                          input int rsp_cyc, input logic [DW-1:0] exp_rd);
        logic [AW-1:0] sa;
        logic [DW-1:0] sw, rr;
        logic          wstn, rd, rv, rdy;
        logic          stb;
        exp_q.push_back(exp_rd);
        tb_sel = sel; tb_we = we; tb_addr = addr; tb_wdata = wdata; tb_valid = 1'b1;
        rdy = (sel == 0) ? if0.cmd_ready : if1.cmd_ready;
        chk("issue_ready", {31'd0, rdy}, 32'd1);
        @(posedge clk);
        for (int c = 1; c <= rsp_cyc + 1; c++) begin
            @(negedge clk);
            if (sel == 0) begin
                sa = if0.sciaddr; sw = if0.sciwdata; rr = if0.rsp_rdata;
                wstn = if0.sciwstn; rd = if0.scird; rv = if0.rsp_valid; rdy = if0.cmd_ready;
            end else begin
                sa = if1.sciaddr; sw = if1.sciwdata; rr = if1.rsp_rdata;
                wstn = if1.sciwstn; rd = if1.scird; rv = if1.rsp_valid; rdy = if1.cmd_ready;
            end
            stb = (c >= stb_first) && (c <= stb_last);
            chk("sciaddr", 32'(sa), 32'(addr));
            if (we) chk("sciwdata", 32'(sw), 32'(wdata));
            chk("sciwstn", {31'd0, wstn}, {31'd0, !(we && stb)});
            chk("scird", {31'd0, rd}, {31'd0, !we && stb});
            chk("rsp_valid", {31'd0, rv}, {31'd0, c == rsp_cyc});
            chk("cmd_ready", {31'd0, rdy}, {31'd0, c == rsp_cyc + 1});
            if (rv) begin
                if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
                else chk("rsp_rdata", 32'(rr), 32'(exp_q.pop_front()));
            end
            // Scramble the held command while busy: a second acceptance would show on sciaddr.
            if (c == 1) begin
                tb_addr  = addr ^ 18'h1F;
                tb_wdata = ~wdata;
            end
            if (c == rsp_cyc) tb_valid = 1'b0;
        end
    endtask

    initial begin
        tb_valid = 1'b1; tb_sel = 0; tb_we = 1'b1; tb_addr = 18'h4; tb_wdata = 8'hFF;
        for (int i = 0; i < 32; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        mem0[0] = 8'h12;
        mem1[3] = 8'h78;

        // Reset with a command offered: nothing may be accepted.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready0", {31'd0, if0.cmd_ready}, 32'd0);
        chk("rst_ready1", {31'd0, if1.cmd_ready}, 32'd0);
        chk("rst_state0", 32'(st0), 32'd0);
        chk("rst_sciaddr0", 32'(if0.sciaddr), 32'd0);
        chk("rst_sciwdata0", 32'(if0.sciwdata), 32'd0);
        chk("rst_sciwstn0", {31'd0, if0.sciwstn}, 32'd1);
        chk("rst_scird0", {31'd0, if0.scird}, 32'd0);
        chk("rst_rsp_valid0", {31'd0, if0.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata0", 32'(if0.rsp_rdata), 32'd0);
        chk("rst_sciwstn1", {31'd0, if1.sciwstn}, 32'd1);
        rst = 1'b0;
        tb_valid = 1'b0;
        #1;
        chk("post_rst_ready0", {31'd0, if0.cmd_ready}, 32'd1);
        chk("post_rst_ready1", {31'd0, if1.cmd_ready}, 32'd1);

        // Default timing: write then read, rsp_rdata carried across a write ack, back-to-back.
        do_cmd(0, 1'b1, 18'h4, 8'hA5, 2, 3, 5, 8'h00);
        chk("mem0_4", 32'(mem0[4]), 32'hA5);
        do_cmd(0, 1'b0, 18'h0, 8'h00, 2, 4, 6, 8'h12);
        do_cmd(0, 1'b1, 18'h5, 8'h3C, 2, 3, 5, 8'h12);
        do_cmd(0, 1'b0, 18'h5, 8'h00, 2, 4, 6, 8'h3C);

        // Reset during the write strobe: transaction dropped, no response, target untouched.
        @(negedge clk);
        tb_sel = 0; tb_we = 1'b1; tb_addr = 18'h5; tb_wdata = 8'hEE; tb_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tb_valid = 1'b0;
        @(negedge clk);
        chk("mid_wstn_low", {31'd0, if0.sciwstn}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_wstn_high", {31'd0, if0.sciwstn}, 32'd1);
        chk("mid_state_idle", 32'(st0), 32'd0);
        chk("mid_rsp_valid", {31'd0, if0.rsp_valid}, 32'd0);
        chk("mid_ready", {31'd0, if0.cmd_ready}, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("mid_no_rsp", {31'd0, if0.rsp_valid}, 32'd0);
        end
        chk("mid_mem0_5", 32'(mem0[5]), 32'h3C);
        chk("mid_rsp_rdata", 32'(if0.rsp_rdata), 32'd0);
        do_cmd(0, 1'b0, 18'h5, 8'h00, 2, 4, 6, 8'h3C);

        // Slow timing instance: SETUP=3, WSTB=1, RSTB=4, HOLD=2.
        @(negedge clk);
        do_cmd(1, 1'b1, 18'h9, 8'h5A, 4, 4, 7, 8'h00);
        do_cmd(1, 1'b0, 18'h3, 8'h00, 4, 7, 10, 8'h78);
        do_cmd(1, 1'b0, 18'h9, 8'h00, 4, 7, 10, 8'h5A);
        chk("mem1_9", 32'(mem1[9]), 32'h5A);

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
